onchip_mem_arbiter: RTL and testbench

- Two-port Avalon-MM arbiter that shares the single-port 16384x32 on-chip RAM between two masters: m0 is the Nios CPU data master, m1 is the packet-generator descriptor/payload fetch engine.
- Issues at most one RAM access per clock.
- Uses round-robin arbitration with a configurable hold window.
- Returns each read's data to the master that issued it, one cycle later.

---
 rtl/onchip_mem_arbiter.sv | 89 ++++++++
 tb/tb_onchip_mem_arbiter.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_mem_arbiter.sv
// onchip_mem_arbiter: round-robin, hold-window arbiter sharing one single-port RAM between two Avalon-MM masters.
// Optional grant/contention counters are built when ONCHIP_MEM_ARB_STATS_EN is defined.
module onchip_mem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     m0_address,
  input  logic [DATA_W/8-1:0]   m0_byteenable,
  input  logic                  m0_read,
  input  logic                  m0_write,
  input  logic [DATA_W-1:0]     m0_writedata,
  output logic                  m0_waitrequest,
  output logic [DATA_W-1:0]     m0_readdata,
  output logic                  m0_readdatavalid,
  input  logic [ADDR_W-1:0]     m1_address,
  input  logic [DATA_W/8-1:0]   m1_byteenable,
  input  logic                  m1_read,
  input  logic                  m1_write,
  input  logic [DATA_W-1:0]     m1_writedata,
  output logic                  m1_waitrequest,
  output logic [DATA_W-1:0]     m1_readdata,
  output logic                  m1_readdatavalid,
  output logic [ADDR_W-1:0]     mem_address,
  output logic [DATA_W/8-1:0]   mem_byteenable,
  output logic                  mem_chipselect,
  output logic                  mem_write,
  output logic [DATA_W-1:0]     mem_writedata,
  output logic                  mem_clken,
`ifdef ONCHIP_MEM_ARB_STATS_EN
  input  logic                  stats_clear,
  output logic [31:0]           m0_grant_cnt,
  output logic [31:0]           m1_grant_cnt,
  output logic [31:0]           contention_cnt,
`endif
  input  logic [DATA_W-1:0]     mem_readdata
);
  logic req0, req1, gnt, sel, last_grant, fresh, rd_pend, rd_owner;
  logic [3:0] hold_cnt;
  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;
  assign gnt = ~reset & (req0 | req1);
  // fresh marks "no grant since reset" so the first tie goes to m0
  always_comb sel = ~(req0 & req1) ? req1 :
                    fresh ? 1'b0 :
                    (hold_cnt < 4'(MAX_HOLD - 1)) ? last_grant : ~last_grant;
  assign m0_waitrequest = reset | (req0 & ~(gnt & ~sel));
  assign m1_waitrequest = reset | (req1 & ~(gnt & sel));
  assign mem_chipselect = gnt;
  assign mem_write = gnt & (sel ? m1_write : m0_write);
  assign mem_address = gnt ? (sel ? m1_address : m0_address) : '0;
  assign mem_byteenable = gnt ? (sel ? m1_byteenable : m0_byteenable) : '0;
  assign mem_writedata = gnt ? (sel ? m1_writedata : m0_writedata) : '0;
  assign mem_clken = ~reset;
  assign m0_readdata = mem_readdata;
  assign m1_readdata = mem_readdata;
  assign m0_readdatavalid = rd_pend & ~reset & ~rd_owner;
  assign m1_readdatavalid = rd_pend & ~reset & rd_owner;
  always_ff @(posedge clk)
    if (reset) begin
      last_grant <= 1'b1;
      hold_cnt <= '0;
      fresh <= 1'b1;
      rd_pend <= 1'b0;
      rd_owner <= 1'b0;
    end else begin
      rd_pend <= gnt & (sel ? (m1_read & ~m1_write) : (m0_read & ~m0_write));
      if (gnt) begin
        fresh <= 1'b0;
        rd_owner <= sel;
        last_grant <= sel;
        hold_cnt <= (sel == last_grant) ? hold_cnt + 4'(hold_cnt != 4'hf) : '0;
      end
    end
`ifdef ONCHIP_MEM_ARB_STATS_EN
  always_ff @(posedge clk)
    if (reset | stats_clear) begin
      m0_grant_cnt <= '0;
      m1_grant_cnt <= '0;
      contention_cnt <= '0;
    end else begin
      m0_grant_cnt <= m0_grant_cnt + 32'(gnt & ~sel);
      m1_grant_cnt <= m1_grant_cnt + 32'(gnt & sel);
      contention_cnt <= contention_cnt + 32'(req0 & req1);
    end
`endif
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb_onchip_mem_arbiter: vector table plus read-return scoreboard for onchip_mem_arbiter (MAX_HOLD=4 and MAX_HOLD=1 instances).
module tb_onchip_mem_arbiter;
  localparam int AW = 14, DW = 32, BW = 4;
  logic clk = 1'b0, reset = 1'b1;
  always #5 clk = ~clk;
  logic [AW-1:0] m0_address, m1_address, mem_address;
  logic [BW-1:0] m0_byteenable, m1_byteenable, mem_byteenable;
  logic m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata, m0_readdata, m1_readdata, mem_writedata, mem_readdata;
  logic m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
  logic mem_chipselect, mem_write, mem_clken;
`ifdef ONCHIP_MEM_ARB_STATS_EN
  logic stats_clear = 1'b0;
  logic [31:0] m0_grant_cnt, m1_grant_cnt, contention_cnt;
`endif
  onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read), .m0_write(m0_write),
    .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read), .m1_write(m1_write),
    .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_clken(mem_clken),
`ifdef ONCHIP_MEM_ARB_STATS_EN
    .stats_clear(stats_clear), .m0_grant_cnt(m0_grant_cnt), .m1_grant_cnt(m1_grant_cnt),
    .contention_cnt(contention_cnt),
`endif
    .mem_readdata(mem_readdata)
  );
  logic b_w = 1'b0;
  logic b_m0_wr, b_m1_wr, b_m0_rdv, b_m1_rdv, b_cs, b_we, b_clken;
  logic [DW-1:0] b_m0_rd, b_m1_rd, b_wd;
  logic [AW-1:0] b_addr;
  logic [BW-1:0] b_be;
`ifdef ONCHIP_MEM_ARB_STATS_EN
  logic [31:0] b_c0, b_c1, b_cc;
`endif
  onchip_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(1)) dut_alt (
    .clk(clk), .reset(reset),
    .m0_address(14'd1), .m0_byteenable(4'hF), .m0_read(1'b0), .m0_write(b_w),
    .m0_writedata(32'h0000_0001), .m0_waitrequest(b_m0_wr), .m0_readdata(b_m0_rd),
    .m0_readdatavalid(b_m0_rdv),
    .m1_address(14'd2), .m1_byteenable(4'hF), .m1_read(1'b0), .m1_write(b_w),
    .m1_writedata(32'h0000_0002), .m1_waitrequest(b_m1_wr), .m1_readdata(b_m1_rd),
    .m1_readdatavalid(b_m1_rdv),
    .mem_address(b_addr), .mem_byteenable(b_be), .mem_chipselect(b_cs),
    .mem_write(b_we), .mem_writedata(b_wd), .mem_clken(b_clken),
`ifdef ONCHIP_MEM_ARB_STATS_EN
    .stats_clear(1'b0), .m0_grant_cnt(b_c0), .m1_grant_cnt(b_c1), .contention_cnt(b_cc),
`endif
    .mem_readdata(32'h0)
  );
  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd, input logic [BW-1:0] be);
    merge = old;
    for (int b = 0; b < BW; b++) if (be[b]) merge[8*b +: 8] = wd[8*b +: 8];
  endfunction
  logic [DW-1:0] ram [0:2**AW-1];
  initial for (int i = 0; i < 2**AW; i++) ram[i] = '0;
  always @(posedge clk) if (mem_chipselect && mem_clken) begin
    mem_readdata <= ram[mem_address];
    if (mem_write) ram[mem_address] <= merge(ram[mem_address], mem_writedata, mem_byteenable);
  end
  logic [DW-1:0] exp_mem [int];
  function automatic logic [DW-1:0] rd(input int a);
    rd = exp_mem.exists(a) ? exp_mem[a] : '0;
  endfunction
  typedef struct { logic own; logic [DW-1:0] data; } rd_t;
  rd_t sb [$];
  int n = 0, bad = 0;
  typedef struct {
    logic r0, w0; logic [AW-1:0] a0; logic [BW-1:0] e0; logic [DW-1:0] d0;
    logic r1, w1; logic [AW-1:0] a1; logic [BW-1:0] e1; logic [DW-1:0] d1;
    logic [1:0] g;
  } vec_t;
  vec_t tv [13];
  task automatic drive(input vec_t v);
    m0_read = v.r0; m0_write = v.w0; m0_address = v.a0; m0_byteenable = v.e0; m0_writedata = v.d0;
    m1_read = v.r1; m1_write = v.w1; m1_address = v.a1; m1_byteenable = v.e1; m1_writedata = v.d1;
  endtask
  // inputs already driven after a falling edge; g: 0 none, 1 m0, 2 m1
  task automatic step(input logic [1:0] g, input string nm);
    logic r0, r1;
    logic [54:0] got, want;
    rd_t e;
    logic ok;
    #1;
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    want = {reset | (r0 && g != 2'd1), reset | (r1 && g != 2'd2), g != 2'd0,
            g == 2'd1 ? m0_write : g == 2'd2 ? m1_write : 1'b0,
            g == 2'd1 ? m0_address : g == 2'd2 ? m1_address : 14'd0,
            g == 2'd1 ? m0_byteenable : g == 2'd2 ? m1_byteenable : 4'd0,
            g == 2'd1 ? m0_writedata : g == 2'd2 ? m1_writedata : 32'd0, ~reset};
    got = {m0_waitrequest, m1_waitrequest, mem_chipselect, mem_write, mem_address,
           mem_byteenable, mem_writedata, mem_clken};
    n++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s grant: got %h want %h", nm, got, want);
    end
    if (reset) sb.delete();
    n++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      ok = (m0_readdatavalid === !e.own) && (m1_readdatavalid === e.own) &&
           ((e.own ? m1_readdata : m0_readdata) === e.data);
      if (!ok) begin
        bad++;
        $display("FAIL %s rdata: got v0=%b v1=%b d0=%h d1=%h want m%0d data %h", nm,
                 m0_readdatavalid, m1_readdatavalid, m0_readdata, m1_readdata, e.own, e.data);
      end
    end else if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
      bad++;
      $display("FAIL %s rdv: got v0=%b v1=%b want none", nm, m0_readdatavalid, m1_readdatavalid);
    end
    if (g == 2'd1) begin
      if (m0_write) exp_mem[int'(m0_address)] = merge(rd(int'(m0_address)), m0_writedata, m0_byteenable);
      else sb.push_back('{1'b0, rd(int'(m0_address))});
    end else if (g == 2'd2) begin
      if (m1_write) exp_mem[int'(m1_address)] = merge(rd(int'(m1_address)), m1_writedata, m1_byteenable);
      else sb.push_back('{1'b1, rd(int'(m1_address))});
    end
    @(negedge clk);
  endtask
  task automatic idle();
    m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = '0; m0_writedata = '0;
    m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = '0; m1_writedata = '0;
  endtask
  task automatic do_reset();
    idle();
    reset = 1'b1;
    step(2'd0, "reset");
    reset = 1'b0;
  endtask
  initial begin
    tv[0]  = '{0, 1, 14'h0010, 4'hF, 32'hDEADBEEF, 0, 0, 14'h0000, 4'h0, 32'h0, 2'd1};
    tv[1]  = '{0, 0, 14'h0000, 4'h0, 32'h0,        1, 0, 14'h0010, 4'hF, 32'h0, 2'd2};
    tv[2]  = '{0, 0, 14'h0000, 4'h0, 32'h0,        0, 0, 14'h0000, 4'h0, 32'h0, 2'd0};
    tv[3]  = '{0, 1, 14'h3FFF, 4'hF, 32'h12345678, 0, 0, 14'h0000, 4'h0, 32'h0, 2'd1};
    tv[4]  = '{1, 0, 14'h3FFF, 4'h3, 32'h0,        0, 0, 14'h0000, 4'h0, 32'h0, 2'd1};
    tv[5]  = '{0, 0, 14'h0000, 4'h0, 32'h0,        0, 0, 14'h0000, 4'h0, 32'h0, 2'd0};
    tv[6]  = '{1, 1, 14'h0020, 4'hF, 32'hA5A5A5A5, 0, 0, 14'h0000, 4'h0, 32'h0, 2'd1};
    tv[7]  = '{0, 0, 14'h0000, 4'h0, 32'h0,        1, 0, 14'h0020, 4'hF, 32'h0, 2'd2};
    tv[8]  = '{1, 0, 14'h0010, 4'hF, 32'h0,        1, 0, 14'h3FFF, 4'hF, 32'h0, 2'd2};
    tv[9]  = '{0, 0, 14'h0000, 4'h0, 32'h0,        0, 0, 14'h0000, 4'h0, 32'h0, 2'd0};
    tv[10] = '{0, 0, 14'h0000, 4'h0, 32'h0,        0, 1, 14'h0010, 4'h2, 32'h11223344, 2'd2};
    tv[11] = '{1, 0, 14'h0010, 4'hF, 32'h0,        0, 0, 14'h0000, 4'h0, 32'h0, 2'd1};
    tv[12] = '{0, 0, 14'h0000, 4'h0, 32'h0,        0, 0, 14'h0000, 4'h0, 32'h0, 2'd0};
    idle();
    @(negedge clk);
    do_reset();
    do_reset();
    foreach (tv[i]) begin
      drive(tv[i]);
      step(tv[i].g, $sformatf("vec%0d", i));
    end
    do_reset();
    for (int i = 0; i < 16; i++) begin
      m0_read = 1; m0_address = 14'h0010 + 14'(i); m0_byteenable = 4'hF;
      m1_read = 1; m1_address = 14'h3000 + 14'(i); m1_byteenable = 4'hF;
      step(((i / 4) % 2) != 0 ? 2'd2 : 2'd1, $sformatf("rr%0d", i));
    end
    idle();
    m1_read = 1; m1_address = 14'h3FFF; m1_byteenable = 4'hF;
    step(2'd2, "pre_reset_read");
    idle();
    reset = 1'b1;
    step(2'd0, "mid_read_reset");
    reset = 1'b0;
    step(2'd0, "post_reset_idle");
    for (int i = 0; i < 5; i++) begin
      m0_read = 1; m0_address = 14'h0020; m0_byteenable = 4'hF;
      m1_read = 1; m1_address = 14'h0010; m1_byteenable = 4'hF;
      step(i < 4 ? 2'd1 : 2'd2, $sformatf("post_rst%0d", i));
    end
    idle();
    step(2'd0, "drain");
    b_w = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      n++;
      if (!(b_we === 1'b1 && b_cs === 1'b1 && b_m0_wr === i[0] && b_m1_wr === !i[0] &&
            b_addr === (i[0] ? 14'd2 : 14'd1))) begin
        bad++;
        $display("FAIL alt%0d: got we=%b wr0=%b wr1=%b addr=%h want we=1 grant m%0d", i,
                 b_we, b_m0_wr, b_m1_wr, b_addr, i[0]);
      end
      @(negedge clk);
    end
    b_w = 1'b0;
`ifdef ONCHIP_MEM_ARB_STATS_EN
    do_reset();
    for (int i = 0; i < 10; i++) begin
      m0_write = 1; m0_address = 14'h0100; m0_byteenable = 4'hF; m0_writedata = 32'(i);
      m1_write = 1; m1_address = 14'h0200; m1_byteenable = 4'hF; m1_writedata = 32'(i);
      step(((i / 4) % 2) != 0 ? 2'd2 : 2'd1, $sformatf("stat%0d", i));
    end
    idle();
    #1;
    n++;
    if (contention_cnt !== 32'd10 || m0_grant_cnt !== 32'd6 || m1_grant_cnt !== 32'd4) begin
      bad++;
      $display("FAIL stats: got cont=%0d g0=%0d g1=%0d want 10 6 4", contention_cnt, m0_grant_cnt, m1_grant_cnt);
    end
    stats_clear = 1'b1;
    @(negedge clk);
    stats_clear = 1'b0;
    #1;
    n++;
    if (contention_cnt !== 0 || m0_grant_cnt !== 0 || m1_grant_cnt !== 0) begin
      bad++;
      $display("FAIL stats_clear: got cont=%0d g0=%0d g1=%0d want 0 0 0", contention_cnt, m0_grant_cnt, m1_grant_cnt);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n, bad);
    $finish;
  end
endmodule
